drp_master: RTL

- Command-driven initiator for the DRP port of the ClockSources MMCM. It is the driving end of the drp_di/drp_den/drp_dwe/drp_daddr/drp_do/drp_drdy interface.
- Accepts read, write and read-modify-write commands over a valid/ready command channel.
- Sequences single-cycle DRP strobes, waits for drp_drdy with a timeout, and returns the read data and an error flag over a valid/ready response channel.
- Sits between a control source (AXI-lite register bank or sequencer) and the MMCM DRP pins, all in the drp_dclk domain.

---
 rtl/drp_pkg.sv | 20 ++
 rtl/drp_master.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/drp_pkg.sv
// Shared definitions for the MMCM DRP initiator: op encodings, FSM states and port widths.
package drp_pkg;

  localparam int DRP_ADDR_W = 7;
  localparam int DRP_DATA_W = 16;

  localparam logic [1:0] DRP_OP_RD  = 2'b00;
  localparam logic [1:0] DRP_OP_WR  = 2'b01;
  localparam logic [1:0] DRP_OP_RMW = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_RESP
  } drp_state_t;

endpackage

// File: rtl/drp_master.sv
// Command-driven DRP initiator: read / write / read-modify-write with drdy timeout,
// one command in flight, result returned on a valid/ready response channel.
module drp_master
  import drp_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int ADDR_W         = DRP_ADDR_W,
  parameter int DATA_W         = DRP_DATA_W
) (
  input  logic              drp_dclk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic [DATA_W-1:0] cmd_mask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              drp_den,
  output logic              drp_dwe,
  output logic [ADDR_W-1:0] drp_daddr,
  output logic [DATA_W-1:0] drp_di,
  input  logic [DATA_W-1:0] drp_do,
  input  logic              drp_drdy
);

  localparam int              CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  drp_state_t        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [1:0]        op_reg, op_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic [DATA_W-1:0] mask_reg, mask_next;
  logic [DATA_W-1:0] rd_reg, rd_next;

  logic              den_next, dwe_next, rsp_valid_next, rsp_err_next, busy_next;
  logic [ADDR_W-1:0] daddr_next;
  logic [DATA_W-1:0] di_next, rsp_data_next;
  logic              timed_out;

  assign cmd_ready = (state_reg == ST_IDLE);
  assign timed_out = (cnt_reg == CNT_LIMIT);

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    op_next        = op_reg;
    addr_next      = addr_reg;
    data_next      = data_reg;
    mask_next      = mask_reg;
    rd_next        = rd_reg;
    den_next       = 1'b0;
    dwe_next       = 1'b0;
    daddr_next     = drp_daddr;
    di_next        = drp_di;
    rsp_valid_next = rsp_valid;
    rsp_data_next  = rsp_data;
    rsp_err_next   = rsp_err;

    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_next   = cmd_op;
          addr_next = cmd_addr;
          data_next = cmd_data;
          mask_next = cmd_mask;
          if (cmd_op == DRP_OP_RD || cmd_op == DRP_OP_RMW) begin
            state_next = ST_RD_REQ;
            den_next   = 1'b1;
            daddr_next = cmd_addr;
          end else if (cmd_op == DRP_OP_WR) begin
            state_next = ST_WR_REQ;
            den_next   = 1'b1;
            dwe_next   = 1'b1;
            daddr_next = cmd_addr;
            di_next    = cmd_data;
          end else begin
            state_next     = ST_RESP;
            rsp_valid_next = 1'b1;
            rsp_data_next  = '0;
            rsp_err_next   = 1'b1;
          end
        end
      end
      ST_RD_REQ: begin
        state_next = ST_RD_WAIT;
        cnt_next   = '0;
      end
      ST_RD_WAIT: begin
        // drdy is tested before the limit so a response on the last cycle still succeeds
        if (drp_drdy) begin
          rd_next = drp_do;
          if (op_reg == DRP_OP_RMW) begin
            state_next = ST_WR_REQ;
            den_next   = 1'b1;
            dwe_next   = 1'b1;
            daddr_next = addr_reg;
            di_next    = (drp_do & ~mask_reg) | (data_reg & mask_reg);
          end else begin
            state_next     = ST_RESP;
            rsp_valid_next = 1'b1;
            rsp_data_next  = drp_do;
            rsp_err_next   = 1'b0;
          end
        end else if (timed_out) begin
          state_next     = ST_RESP;
          rsp_valid_next = 1'b1;
          rsp_data_next  = '0;
          rsp_err_next   = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_WR_REQ: begin
        state_next = ST_WR_WAIT;
        cnt_next   = '0;
      end
      ST_WR_WAIT: begin
        if (drp_drdy) begin
          state_next     = ST_RESP;
          rsp_valid_next = 1'b1;
          rsp_data_next  = (op_reg == DRP_OP_RMW) ? rd_reg : '0;
          rsp_err_next   = 1'b0;
        end else if (timed_out) begin
          state_next     = ST_RESP;
          rsp_valid_next = 1'b1;
          rsp_data_next  = '0;
          rsp_err_next   = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_next     = ST_IDLE;
          rsp_valid_next = 1'b0;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    busy_next = (state_next != ST_IDLE);
  end

  always_ff @(posedge drp_dclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      op_reg    <= DRP_OP_RD;
      addr_reg  <= '0;
      data_reg  <= '0;
      mask_reg  <= '0;
      rd_reg    <= '0;
      drp_den   <= 1'b0;
      drp_dwe   <= 1'b0;
      drp_daddr <= '0;
      drp_di    <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      op_reg    <= op_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      mask_reg  <= mask_next;
      rd_reg    <= rd_next;
      drp_den   <= den_next;
      drp_dwe   <= dwe_next;
      drp_daddr <= daddr_next;
      drp_di    <= di_next;
      rsp_valid <= rsp_valid_next;
      rsp_data  <= rsp_data_next;
      rsp_err   <= rsp_err_next;
      busy      <= busy_next;
    end
  end

endmodule
